// File: rtl/pbus_tx.sv
// PBUS address transmitter: sends an optional sprite (C) address then an
// optional fix (S) address to the cartridge, each framed by setup/strobe/hold.
module pbus_tx #(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 2,
   parameter int T_HOLD  = 1
) (
   input  logic        CLK_24M,
   input  logic        nRESET,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_C_EN,
   input  logic        REQ_S_EN,
   input  logic [22:0] REQ_C_ADDR,
   input  logic [15:0] REQ_S_ADDR,
   input  logic        REQ_CA4,
   input  logic        REQ_S2H1,
   output logic [22:0] PBUS,
   output logic        PCK1B,
   output logic        PCK2B,
   output logic        CA4,
   output logic        S2H1,
   output logic        DONE,
   output logic [2:0]  dbg_state
);

   // Handshake: a request transfers on a rising edge where REQ_VALID and
   // REQ_READY are both high; REQ_READY depends only on state (high in IDLE).

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      C_SETUP = 3'd1,
      C_PULSE = 3'd2,
      C_HOLD  = 3'd3,
      S_SETUP = 3'd4,
      S_PULSE = 3'd5,
      S_HOLD  = 3'd6
   } state_t;

   // The counter is loaded with (T-1) on entry and the state advances when it reaches 0.
   localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
   localparam logic [3:0] LD_PULSE = 4'(T_PULSE - 1);
   localparam logic [3:0] LD_HOLD  = 4'(T_HOLD - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic        done_nxt;
   logic        accept;
   logic [22:0] c_addr_q;
   logic [15:0] s_addr_q;
   logic        s_en_q;
   logic [22:0] c_src;
   logic [15:0] s_src;
   logic [22:0] pbus_nxt;

   assign REQ_READY = (state == IDLE);
   assign accept    = REQ_VALID && REQ_READY;
   assign dbg_state = state;

   // On the accept edge the address registers are not yet loaded, so the
   // first setup cycle takes its bus value straight from the request.
   assign c_src = accept ? REQ_C_ADDR : c_addr_q;
   assign s_src = accept ? REQ_S_ADDR : s_addr_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (REQ_C_EN) begin
                  state_nxt = C_SETUP;
                  cnt_nxt   = LD_SETUP;
               end else if (REQ_S_EN) begin
                  state_nxt = S_SETUP;
                  cnt_nxt   = LD_SETUP;
               end else begin
                  done_nxt  = 1'b1;
               end
            end
         end
         C_SETUP: begin
            if (cnt == 4'd0) begin
               state_nxt = C_PULSE;
               cnt_nxt   = LD_PULSE;
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         C_PULSE: begin
            if (cnt == 4'd0) begin
               state_nxt = C_HOLD;
               cnt_nxt   = LD_HOLD;
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         C_HOLD: begin
            if (cnt == 4'd0) begin
               if (s_en_q) begin
                  state_nxt = S_SETUP;
                  cnt_nxt   = LD_SETUP;
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = 4'd0;
                  done_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         S_SETUP: begin
            if (cnt == 4'd0) begin
               state_nxt = S_PULSE;
               cnt_nxt   = LD_PULSE;
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         S_PULSE: begin
            if (cnt == 4'd0) begin
               state_nxt = S_HOLD;
               cnt_nxt   = LD_HOLD;
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         S_HOLD: begin
            if (cnt == 4'd0) begin
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      pbus_nxt = 23'd0;
      case (state_nxt)
         C_SETUP, C_PULSE, C_HOLD: pbus_nxt = c_src;
         S_SETUP, S_PULSE, S_HOLD: pbus_nxt = {7'd0, s_src};
         default:                  pbus_nxt = 23'd0;
      endcase
   end

   // Bus and strobes are decoded from the next state and registered, so they
   // change only on clock edges and never glitch.
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         PBUS     <= 23'd0;
         PCK1B    <= 1'b0;
         PCK2B    <= 1'b0;
         CA4      <= 1'b0;
         S2H1     <= 1'b0;
         DONE     <= 1'b0;
         c_addr_q <= 23'd0;
         s_addr_q <= 16'd0;
         s_en_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         PBUS  <= pbus_nxt;
         PCK1B <= (state_nxt == C_PULSE);
         PCK2B <= (state_nxt == S_PULSE);
         DONE  <= done_nxt;
         if (accept) begin
            c_addr_q <= REQ_C_ADDR;
            s_addr_q <= REQ_S_ADDR;
            s_en_q   <= REQ_S_EN;
            CA4      <= REQ_CA4;
            S2H1     <= REQ_S2H1;
         end
      end
   end

endmodule

// File: tb/tb_pbus_tx.sv
// Bench for pbus_tx: instance 0 uses default timing, instance 1 uses 1/1/1.
// A driver pushes expected strobe events and completions; a monitor checks them.
module tb_pbus_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit fin [2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
   endtask

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int TS = (g == 0) ? 2 : 1;
      localparam int TP = (g == 0) ? 2 : 1;
      localparam int TH = 1;
      localparam int PH = TS + TP + TH;

      logic        rst_n, valid, ready, c_en, s_en, ca4_in, s2h1_in;
      logic [22:0] c_addr;
      logic [15:0] s_addr;
      logic [22:0] pbus;
      logic        pck1b, pck2b, ca4, s2h1, done;
      logic [2:0]  dbg;

      pbus_tx #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH)) dut (
         .CLK_24M   (clk),
         .nRESET    (rst_n),
         .REQ_VALID (valid),
         .REQ_READY (ready),
         .REQ_C_EN  (c_en),
         .REQ_S_EN  (s_en),
         .REQ_C_ADDR(c_addr),
         .REQ_S_ADDR(s_addr),
         .REQ_CA4   (ca4_in),
         .REQ_S2H1  (s2h1_in),
         .PBUS      (pbus),
         .PCK1B     (pck1b),
         .PCK2B     (pck2b),
         .CA4       (ca4),
         .S2H1      (s2h1),
         .DONE      (done),
         .dbg_state (dbg)
      );

      int cyc = 0;
      always @(posedge clk) cyc <= cyc + 1;

      // {kind (0=C,1=S), bus value, cycle of strobe rise}
      logic [55:0] exp_q[$];
      // {CA4, S2H1, cycle of DONE}
      logic [33:0] done_q[$];

      task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
         chk($sformatf("i%0d_%s", g, nm), act, exp);
      endtask

      function automatic int busy(input logic ce, input logic se);
         return (ce ? PH : 0) + (se ? PH : 0);
      endfunction

      // Bit 22 set keeps a C address distinct from any zero-extended S address.
      function automatic logic [22:0] rc();
         return 23'($urandom) | 23'h400000;
      endfunction

      function automatic logic [15:0] rs();
         return 16'($urandom_range(1, 65535));
      endfunction

      task automatic send(input logic ce, input logic se, input logic [22:0] ca,
                          input logic [15:0] sa, input logic a4, input logic h1,
                          input int exp_wait);
         int w = 0;
         int base;
         @(negedge clk);
         valid = 1'b1; c_en = ce; s_en = se; c_addr = ca; s_addr = sa;
         ca4_in = a4; s2h1_in = h1;
         while (!ready && w < 200) begin
            @(negedge clk);
            w++;
         end
         ck("accept_seen", ready, 1'b1);
         if (exp_wait >= 0) ck("accept_wait", w, exp_wait);
         if (ready) begin
            base = cyc + 1;
            if (ce) exp_q.push_back({1'b0, ca, 32'(base + TS)});
            if (se) exp_q.push_back({1'b1, {7'd0, sa}, 32'(base + (ce ? PH : 0) + TS)});
            done_q.push_back({a4, h1, 32'(base + busy(ce, se))});
         end
      endtask

      task automatic idle(input int n);
         repeat (n) begin
            @(negedge clk);
            valid = 1'b0; c_en = 1'($urandom); s_en = 1'($urandom);
            c_addr = 23'($urandom); s_addr = 16'($urandom);
            ca4_in = 1'($urandom); s2h1_in = 1'($urandom);
         end
      endtask

      task automatic drain();
         int t = 0;
         while ((done_q.size() != 0 || exp_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
         end
         ck("drain_done_q", done_q.size(), 0);
         ck("drain_strobe_q", exp_q.size(), 0);
      endtask

      task automatic reset_phase();
         rst_n = 1'b0; valid = 1'b0; c_en = 1'b0; s_en = 1'b0;
         c_addr = '0; s_addr = '0; ca4_in = 1'b0; s2h1_in = 1'b0;
         repeat (3) @(negedge clk);
         ck("reset_ready", ready, 1'b1);
         ck("reset_pbus", pbus, 0);
         ck("reset_pck1b", pck1b, 1'b0);
         ck("reset_pck2b", pck2b, 1'b0);
         ck("reset_ca4", ca4, 1'b0);
         ck("reset_s2h1", s2h1, 1'b0);
         ck("reset_done", done, 1'b0);
         #2 rst_n = 1'b1;
      endtask

      task automatic b2b(input int n);
         int   prev = 0;
         logic ce, se;
         for (int i = 0; i < n; i++) begin
            ce = 1'(i != 2);
            se = 1'(i != 1);
            send(ce, se, rc(), rs(), 1'(i), 1'(i >> 1), prev);
            prev = busy(ce, se);
         end
         idle(1);
         drain();
      endtask

      task automatic rand_reqs(input int n);
         for (int i = 0; i < n; i++) begin
            send(1'($urandom), 1'($urandom), rc(), rs(), 1'($urandom), 1'($urandom), -1);
            idle($urandom_range(0, 3));
         end
         drain();
      endtask

      // Monitor state
      logic        p1_prev = 1'b0, p2_prev = 1'b0, hold_pend = 1'b0;
      logic [22:0] pbus_prev = '0, lat = '0;
      int          hi1 = 0, hi2 = 0, since = 0, fall_cyc = 0;

      task automatic on_rise(input logic k);
         logic [55:0] e;
         ck("strobe_expected", exp_q.size() != 0, 1'b1);
         ck("strobe_exclusive", pck1b & pck2b, 1'b0);
         ck("setup_len", cyc - since, TS);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            ck("strobe_kind", k, e[55]);
            ck("strobe_addr", pbus, e[54:32]);
            ck("strobe_cycle", cyc, e[31:0]);
         end
         lat = pbus;
      endtask

      task automatic on_fall(input int hi);
         ck("pulse_width", hi, TP);
         ck("hold_addr", pbus, lat);
         hold_pend = 1'b1;
         fall_cyc  = cyc;
      endtask

      initial forever begin
         logic [33:0] d;
         @(negedge clk);
         if (!rst_n) begin
            p1_prev = 1'b0; p2_prev = 1'b0; hi1 = 0; hi2 = 0;
            hold_pend = 1'b0; pbus_prev = '0; since = cyc;
         end else begin
            if (pbus !== pbus_prev) begin
               if (hold_pend) begin
                  ck("hold_len", cyc - fall_cyc, TH);
                  hold_pend = 1'b0;
               end
               pbus_prev = pbus;
               since     = cyc;
            end
            if (pck1b && !p1_prev) on_rise(1'b0);
            if (pck2b && !p2_prev) on_rise(1'b1);
            if (pck1b) hi1++;
            if (pck2b) hi2++;
            if (!pck1b && p1_prev) begin on_fall(hi1); hi1 = 0; end
            if (!pck2b && p2_prev) begin on_fall(hi2); hi2 = 0; end
            if (done) begin
               ck("done_expected", done_q.size() != 0, 1'b1);
               if (done_q.size() != 0) begin
                  d = done_q.pop_front();
                  ck("done_cycle", cyc, d[31:0]);
                  ck("done_ca4", ca4, d[33]);
                  ck("done_s2h1", s2h1, d[32]);
                  ck("done_pbus_idle", pbus, 0);
               end
            end
            p1_prev = pck1b;
            p2_prev = pck2b;
         end
      end

      if (g == 0) begin : dir
         initial begin
            int t;
            reset_phase();
            send(1'b1, 1'b1, 23'h5A5A5A, 16'hBEEF, 1'b1, 1'b0, 0);
            idle(2);
            drain();
            send(1'b1, 1'b0, 23'h523456, 16'h0F0F, 1'b0, 1'b1, 0);
            idle(1);
            drain();
            for (int i = 0; i < 4; i++) send(1'b0, 1'b0, rc(), rs(), 1'(i), 1'(i >> 1), 0);
            idle(1);
            drain();
            b2b(4);
            // Abort in the middle of the sprite strobe.
            send(1'b1, 1'b1, 23'h4ABCDE, 16'h1234, 1'b1, 1'b1, 0);
            t = 0;
            while (!pck1b && t < 50) begin
               @(negedge clk);
               t++;
            end
            ck("reach_c_pulse", pck1b, 1'b1);
            #2 rst_n = 1'b0;
            valid = 1'b0;
            #1;
            ck("abort_pck1b", pck1b, 1'b0);
            ck("abort_pbus", pbus, 0);
            ck("abort_done", done, 1'b0);
            ck("abort_ca4", ca4, 1'b0);
            exp_q.delete();
            done_q.delete();
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);
            ck("ready_after_reset", ready, 1'b1);
            repeat (6) begin
               @(negedge clk);
               ck("no_pck2b_after_abort", pck2b, 1'b0);
               ck("no_done_after_abort", done, 1'b0);
            end
            send(1'b1, 1'b1, 23'h6C0FFE, 16'hCAFE, 1'b0, 1'b1, 0);
            idle(1);
            drain();
            rand_reqs(40);
            fin[0] = 1'b1;
         end
      end else begin : dir
         initial begin
            reset_phase();
            send(1'b1, 1'b1, 23'h5A5A5A, 16'hBEEF, 1'b0, 1'b1, 0);
            idle(1);
            drain();
            b2b(4);
            rand_reqs(30);
            fin[1] = 1'b1;
         end
      end
   end

   initial begin
      wait (fin[0] && fin[1]);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not complete, passed=%0d total=%0d", n_pass, n_total);
      $fatal(1, "time limit reached");
   end

endmodule
